spi_xfer_arbiter: RTL and testbench

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_xfer_arbiter_if.sv | 19 +
 rtl/spi_xfer_arbiter.sv | 171 +++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// rtl/spi_xfer_arbiter_if.sv - SPI-master register-port bundle between the arbiter and the SPI master core
interface spi_xfer_arbiter_if;
  logic        spi_sel;
  logic        spi_wr_n;
  logic        spi_rd_n;
  logic [2:0]  spi_addr;
  logic [15:0] spi_wdata;
  logic [15:0] spi_rdata;

  modport master (
    output spi_sel, spi_wr_n, spi_rd_n, spi_addr, spi_wdata,
    input  spi_rdata
  );

  modport slave (
    input  spi_sel, spi_wr_n, spi_rd_n, spi_addr, spi_wdata,
    output spi_rdata
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin arbiter running one-byte SPI transfers for two requesters
// Optional poll timeout with err pulse: define SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
  parameter int POLL_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        ss0,
  input  logic [1:0]        ss1,
  input  logic [7:0]        tx0,
  input  logic [7:0]        tx1,
  output logic              done0,
  output logic              done1,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              err,
  spi_xfer_arbiter_if.master spi
);

  typedef enum logic [2:0] {IDLE, WR_SS, WR_TX, POLL, RD_RX, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] phase;
  logic       ptr;
  logic       owner;
  logic [1:0] ss_q;
  logic [7:0] tx_q;
  logic       grant;
  logic       winner;
  logic       acc_end;
  logic       in_access;
  logic       poll_last;

  // Each register access: phases 0,1 drive the strobe, phase 2 is the gap where read data is sampled.
  always_comb begin
    state_nxt     = state;
    grant         = 1'b0;
    winner        = (req0 && req1) ? ptr : req1;
    acc_end       = (phase == 2'd2);
    in_access     = 1'b0;
    spi.spi_sel   = 1'b0;
    spi.spi_wr_n  = 1'b1;
    spi.spi_rd_n  = 1'b1;
    spi.spi_addr  = 3'd0;
    spi.spi_wdata = 16'd0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = WR_SS;
        end
      end
      WR_SS: begin
        in_access = 1'b1;
        if (!acc_end) begin
          spi.spi_sel   = 1'b1;
          spi.spi_wr_n  = 1'b0;
          spi.spi_addr  = 3'd5;
          spi.spi_wdata = {14'd0, ss_q};
        end else begin
          state_nxt = WR_TX;
        end
      end
      WR_TX: begin
        in_access = 1'b1;
        if (!acc_end) begin
          spi.spi_sel   = 1'b1;
          spi.spi_wr_n  = 1'b0;
          spi.spi_addr  = 3'd1;
          spi.spi_wdata = {8'd0, tx_q};
        end else begin
          state_nxt = POLL;
        end
      end
      POLL: begin
        in_access = 1'b1;
        if (!acc_end) begin
          spi.spi_sel  = 1'b1;
          spi.spi_rd_n = 1'b0;
          spi.spi_addr = 3'd2;
        end else if (spi.spi_rdata[7]) begin
          state_nxt = RD_RX;
        end else if (poll_last) begin
          state_nxt = DONE;
        end
      end
      RD_RX: begin
        in_access = 1'b1;
        if (!acc_end) begin
          spi.spi_sel  = 1'b1;
          spi.spi_rd_n = 1'b0;
          spi.spi_addr = 3'd0;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      phase   <= 2'd0;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      ss_q    <= 2'd0;
      tx_q    <= 8'd0;
      rx_data <= 8'd0;
    end else begin
      state <= state_nxt;
      phase <= (in_access && !acc_end) ? phase + 2'd1 : 2'd0;
      if (grant) begin
        owner <= winner;
        ptr   <= ~winner;
        ss_q  <= winner ? ss1 : ss0;
        tx_q  <= winner ? tx1 : tx0;
      end
      if (state == RD_RX && acc_end) begin
        rx_data <= spi.spi_rdata[7:0];
      end
    end
  end

  assign busy  = (state != IDLE);
  assign done0 = (state == DONE) && !owner;
  assign done1 = (state == DONE) && owner;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [9:0] poll_cnt;
  logic       timed_out;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      poll_cnt  <= 10'd0;
      timed_out <= 1'b0;
    end else begin
      if (state == WR_TX && acc_end) begin
        poll_cnt <= 10'd0;
      end else if (state == POLL && acc_end) begin
        poll_cnt <= poll_cnt + 10'd1;
      end
      if (grant) begin
        timed_out <= 1'b0;
      end else if (state == POLL && state_nxt == DONE) begin
        timed_out <= 1'b1;
      end
    end
  end

  // poll_cnt counts completed polls, so the access now ending is number poll_cnt+1.
  assign poll_last = ({1'b0, poll_cnt} + 11'd1) >= 11'(POLL_LIMIT);
  assign err       = (state == DONE) && timed_out;
`else
  logic [9:0] unused_poll_limit;
  assign unused_poll_limit = 10'(POLL_LIMIT);
  assign poll_last         = 1'b0;
  assign err               = 1'b0;
`endif

  logic [7:0] unused_rdata_hi;
  assign unused_rdata_hi = spi.spi_rdata[15:8];

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - randomized self-checking bench for spi_xfer_arbiter
module tb_spi_xfer_arbiter;
  localparam int LIMIT = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef logic [19:0] acc_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [1:0] ss0 = 2'b01;
  logic [1:0] ss1 = 2'b01;
  logic [7:0] tx0 = 8'd0;
  logic [7:0] tx1 = 8'd0;
  logic       done0, done1, busy, err;
  logic [7:0] rx_data;

  spi_xfer_arbiter_if spi ();

  spi_xfer_arbiter #(.POLL_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .ss0     (ss0),
    .ss1     (ss1),
    .tx0     (tx0),
    .tx1     (tx1),
    .done0   (done0),
    .done1   (done1),
    .rx_data (rx_data),
    .busy    (busy),
    .err     (err),
    .spi     (spi)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // slave model configuration, owned by the main sequence
  int         slow_polls = 0;
  logic [7:0] rd_byte = 8'd0;

  // bus monitor / slave model state, owned by the monitor
  acc_t log_q[$];
  int   run_len = 0;
  int   proto_err = 0;
  int   poll_idx = 0;
  int   err_outside = 0;

  // reference model state
  int         last = 1;
  logic [7:0] model_rx = 8'd0;

  always @(negedge clk) begin
    if (!reset_n) begin
      run_len = 0;
    end else if (spi.spi_sel) begin
      if (spi.spi_wr_n == spi.spi_rd_n) proto_err++;
      if (run_len == 0) begin
        if (!spi.spi_rd_n) begin
          log_q.push_back({1'b1, spi.spi_addr, 16'h0000});
          if (spi.spi_addr == 3'd2) begin
            spi.spi_rdata = 16'($urandom) & 16'hFF7F;
            if (poll_idx >= slow_polls) spi.spi_rdata[7] = 1'b1;
            poll_idx++;
          end else begin
            spi.spi_rdata = {8'($urandom), rd_byte};
          end
        end else begin
          log_q.push_back({1'b0, spi.spi_addr, spi.spi_wdata});
          if (spi.spi_addr == 3'd5) poll_idx = 0;
        end
      end
      run_len++;
    end else begin
      if (run_len != 0 && run_len != 2) proto_err++;
      run_len = 0;
      if (!spi.spi_wr_n || !spi.spi_rd_n || spi.spi_addr != 3'd0 || spi.spi_wdata != 16'd0)
        proto_err++;
    end
    if (reset_n && err && !(done0 || done1)) err_outside++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int i);
    if (i == 0) begin
      req0 = 1'b1;
      ss0  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      tx0  = 8'($urandom);
    end else begin
      req1 = 1'b1;
      ss1  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      tx1  = 8'($urandom);
    end
  endtask

  // Called at #1 in a cycle where the arbiter is idle and at least one req is set.
  task automatic xfer(input int nr, input logic [7:0] rdb, input bit raise_mid, input bit drop_mid);
    int         exp_who, who, lat, npolls, base, mism, exp_lat;
    bit         to;
    logic [1:0] ess;
    logic [7:0] etx, erx, exp_rx;
    logic       got_err;
    acc_t       exp_q[$];

    exp_who = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
    ess     = (exp_who == 1) ? ss1 : ss0;
    etx     = (exp_who == 1) ? tx1 : tx0;
    slow_polls = nr;
    rd_byte    = rdb;
    to      = TO_EN && (nr >= LIMIT);
    npolls  = to ? LIMIT : nr + 1;
    exp_lat = 3 + 3 + 3 * npolls + (to ? 0 : 3) + 1;
    exp_rx  = to ? model_rx : rdb;
    exp_q.push_back({1'b0, 3'd5, 14'd0, ess});
    exp_q.push_back({1'b0, 3'd1, 8'd0, etx});
    for (int p = 0; p < npolls; p++) exp_q.push_back({1'b1, 3'd2, 16'h0000});
    if (!to) exp_q.push_back({1'b1, 3'd0, 16'h0000});
    base = log_q.size();

    lat = 0;
    who = -1;
    erx = 8'd0;
    got_err = 1'b0;
    for (int c = 0; c < 3000 && who < 0; c++) begin
      @(posedge clk);
      #1;
      if (busy) lat++;
      if (lat == 5) begin
        if (drop_mid) begin
          if (exp_who == 1) begin req1 = 1'b0; ss1 = ~ss1; tx1 = 8'($urandom); end
          else begin req0 = 1'b0; ss0 = ~ss0; tx0 = 8'($urandom); end
        end
        if (raise_mid) begin
          if (exp_who == 0 && !req1) raise(1);
          else if (exp_who == 1 && !req0) raise(0);
        end
      end
      if (done0 || done1) begin
        who     = (done0 && done1) ? 2 : (done1 ? 1 : 0);
        erx     = rx_data;
        got_err = err;
      end
    end
    if (who < 0) begin
      chk("done_seen", 32'd0, 32'd1);
      return;
    end
    chk("who", who, exp_who);
    chk("latency", lat, exp_lat);
    chk("rx_data", erx, exp_rx);
    chk("err_with_done", got_err, to);

    @(posedge clk);
    #1;
    chk("done_one_cycle", {done0, done1, busy}, 3'b000);
    chk("rx_hold", rx_data, exp_rx);
    if (exp_who == 1) req1 = 1'b0;
    else req0 = 1'b0;

    mism = 0;
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
      if (log_q[base + i] !== exp_q[i]) mism++;
    chk("seq_len", log_q.size() - base, exp_q.size());
    chk("seq_data", mism, 0);
    chk("protocol", proto_err, 0);
    chk("err_outside_done", err_outside, 0);

    last = exp_who;
    if (!to) model_rx = rdb;
  endtask

  initial begin
    int lat, dones;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {busy, done0, done1, err}, 4'b0000);
    chk("rst_rx", rx_data, 8'd0);
    chk("rst_bus", {spi.spi_sel, spi.spi_wr_n, spi.spi_rd_n, spi.spi_addr}, 6'b011000);
    chk("rst_wdata", spi.spi_wdata, 16'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single request, ready on first poll
    req0 = 1'b1;
    ss0  = 2'b01;
    tx0  = 8'hA5;
    xfer(0, 8'h3C, 1'b0, 1'b0);

    // contention straight after reset
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    last     = 1;
    model_rx = 8'd0;
    raise(0);
    raise(1);
    xfer(0, 8'($urandom), 1'b0, 1'b0);
    xfer(1, 8'($urandom), 1'b1, 1'b0);
    xfer(0, 8'($urandom), 1'b0, 1'b0);

    // slow slave: five not-ready polls
    raise(1);
    xfer(5, 8'($urandom), 1'b0, 1'b0);

    // reset during WR_TX abandons the transfer
    raise(0);
    lat = 0;
    for (int c = 0; c < 40 && lat < 4; c++) begin
      @(posedge clk);
      #1;
      if (busy) lat++;
    end
    chk("reached_wr_tx", lat, 4);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_bus", {spi.spi_sel, spi.spi_wr_n, spi.spi_rd_n}, 3'b011);
    chk("midrst_ctrl", {busy, done0, done1, err}, 4'b0000);
    chk("midrst_rx", rx_data, 8'd0);
    reset_n  = 1'b1;
    req0     = 1'b0;
    last     = 1;
    model_rx = 8'd0;
    dones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0 || done1 || busy) dones++;
    end
    chk("midrst_silent", dones, 0);
    raise(1);
    xfer(1, 8'($urandom), 1'b0, 1'b0);

    // never-ready slave (times out when the timeout feature is built)
    raise(0);
    xfer(7, 8'($urandom), 1'b0, 1'b0);

    for (int it = 0; it < 24; it++) begin
      int pat;
      if (!req0 && !req1) begin
        repeat (1 + $urandom_range(0, 2)) @(posedge clk);
        #1;
        pat = $urandom_range(0, 2);
        if (pat != 2) raise(0);
        if (pat != 1) raise(1);
      end
      xfer($urandom_range(0, 6), 8'($urandom), ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
